// File: rtl/sha2_eddsa_pkg.sv
// Shared definitions for the EdDSA SHA-2 message-schedule sequencer.
package sha2_eddsa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned SCHED_DEPTH = 16;

    // Round count per SHA-2 variant; 0 flags an unsupported variant.
    function automatic int unsigned rounds_of(input int unsigned mode);
        case (mode)
            224, 256: return 64;
            384, 512: return 80;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/sha2_schedule_ctrl_eddsa.sv
// Sequencer for the SHA-2 message-schedule shift register: 16 load strobes per block,
// then one start strobe per consumed round, each W_t tagged with its round index.
module sha2_schedule_ctrl_eddsa
    import sha2_eddsa_pkg::*;
#(
    parameter int unsigned MODE  = 256,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_start,
    input  logic             abort,
    input  logic             msg_valid,
    output logic             msg_ready,
    output logic             sched_load,
    output logic             sched_start,
    output logic             w_valid,
    input  logic             w_ready,
    output logic [CNT_W-1:0] round,
    output logic             busy,
    output logic             done
);

    localparam int unsigned ROUNDS = rounds_of(MODE);

    generate
        if (ROUNDS == 0) begin : g_bad_mode
            $error("sha2_schedule_ctrl_eddsa: MODE must be 224, 256, 384 or 512");
        end
        if ((64'(1) << CNT_W) < 64'(ROUNDS)) begin : g_bad_cnt_w
            $error("sha2_schedule_ctrl_eddsa: CNT_W too narrow for ROUNDS-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(SCHED_DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State and word/round counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; abort wins over every other transition
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (blk_start) begin
                    state_nxt = ST_LOAD;
                    cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (msg_valid) begin
                    if (cnt == LAST_WORD) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (w_ready) begin
                    if (cnt == LAST_ROUND) begin
                        state_nxt = ST_DONE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end
    end

    // Outputs decoded from state; everything forced low while rst is asserted
    always_comb begin
        msg_ready   = 1'b0;
        sched_load  = 1'b0;
        sched_start = 1'b0;
        w_valid     = 1'b0;
        round       = '0;
        busy        = 1'b0;
        done        = 1'b0;
        if (rst) begin
            case (state)
                ST_LOAD: begin
                    msg_ready  = 1'b1;
                    sched_load = msg_valid & ~abort;
                    busy       = 1'b1;
                end
                ST_RUN: begin
                    w_valid     = 1'b1;
                    round       = cnt;
                    sched_start = w_ready & ~abort;
                    busy        = 1'b1;
                end
                ST_DONE: begin
                    done = 1'b1;
                    busy = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_schedule_ctrl_eddsa.sv
// Directed bench: SHA-256/512 sequencing with a behavioural SHA-256 schedule on the 256 instance.
module tb_sha2_schedule_ctrl_eddsa;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       abort = 1'b0;
    logic       msg_valid = 1'b1;
    logic       w_ready = 1'b1;
    logic       blk_start_a = 1'b0;
    logic       blk_start_b = 1'b0;

    logic       msg_ready_a, sched_load_a, sched_start_a, w_valid_a, busy_a, done_a;
    logic [6:0] round_a;
    logic       msg_ready_b, sched_load_b, sched_start_b, w_valid_b, busy_b, done_b;
    logic [6:0] round_b;

    always #5 clk = ~clk;

    sha2_schedule_ctrl_eddsa #(.MODE(256), .CNT_W(7)) u_dut_a (
        .clk(clk), .rst(rst), .blk_start(blk_start_a), .abort(abort),
        .msg_valid(msg_valid), .msg_ready(msg_ready_a), .sched_load(sched_load_a),
        .sched_start(sched_start_a), .w_valid(w_valid_a), .w_ready(w_ready),
        .round(round_a), .busy(busy_a), .done(done_a)
    );

    sha2_schedule_ctrl_eddsa #(.MODE(512), .CNT_W(7)) u_dut_b (
        .clk(clk), .rst(rst), .blk_start(blk_start_b), .abort(abort),
        .msg_valid(msg_valid), .msg_ready(msg_ready_b), .sched_load(sched_load_b),
        .sched_start(sched_start_b), .w_valid(w_valid_b), .w_ready(w_ready),
        .round(round_b), .busy(busy_b), .done(done_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // SHA-256 padded "abc" block
    function automatic logic [31:0] word_of(input int idx);
        if (idx == 0)  return 32'h61626380;
        if (idx == 15) return 32'h00000018;
        return 32'h0;
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Behavioural schedule register driven by instance A's strobes
    logic [31:0] sw [16];
    int          widx = 0;
    int          base_a = 0;
    logic [31:0] msg_word;
    assign msg_word = word_of(widx - base_a);

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) sw[i] <= 32'h0;
        end else if (sched_load_a) begin
            for (int i = 0; i < 15; i++) sw[i] <= sw[i+1];
            sw[15] <= msg_word;
            widx   <= widx + 1;
        end else if (sched_start_a) begin
            for (int i = 0; i < 15; i++) sw[i] <= sw[i+1];
            sw[15] <= ssig1(sw[14]) + sw[9] + ssig0(sw[1]) + sw[0];
        end
    end

    // Mid-cycle monitor: strobe counts, W capture, round tags, invariants
    int          loads_a = 0, starts_a = 0, dones_a = 0;
    int          starts_b = 0, dones_b = 0;
    int          excl_err = 0, range_err = 0, hold_err = 0;
    logic [31:0] w_log [128];
    logic [6:0]  rlog_b [128];
    logic        prev_wv = 1'b0, prev_st = 1'b0;
    logic [6:0]  prev_round = '0;
    logic [31:0] prev_w = '0;

    always @(negedge clk) begin
        if (sched_load_a)  loads_a  <= loads_a + 1;
        if (sched_start_a) begin
            starts_a        <= starts_a + 1;
            w_log[round_a]  <= sw[0];
        end
        if (done_a) dones_a <= dones_a + 1;
        if (sched_start_b) begin
            starts_b                <= starts_b + 1;
            rlog_b[7'(starts_b)]    <= round_b;
        end
        if (done_b) dones_b <= dones_b + 1;
        if ((sched_load_a && sched_start_a) || (msg_ready_a && w_valid_a) ||
            (sched_load_b && sched_start_b) || (msg_ready_b && w_valid_b))
            excl_err <= excl_err + 1;
        if (w_valid_b && round_b > 7'd79) range_err <= range_err + 1;
        if (w_valid_a && prev_wv && !prev_st && (round_a != prev_round || sw[0] != prev_w))
            hold_err <= hold_err + 1;
        prev_wv    <= w_valid_a;
        prev_st    <= sched_start_a;
        prev_round <= round_a;
        prev_w     <= sw[0];
    end

    function automatic logic [31:0] outs_a();
        return 32'({msg_ready_a, sched_load_a, sched_start_a, w_valid_a, busy_a, done_a, round_a});
    endfunction

    function automatic logic [31:0] outs_b();
        return 32'({msg_ready_b, sched_load_b, sched_start_b, w_valid_b, busy_b, done_b, round_b});
    endfunction

    // Run one block on instance A (sel=0) or B (sel=1); lat = cycles from blk_start to done
    task automatic run_block(input bit sel, input bit rnd, input bit poke, output int lat);
        lat = -1;
        if (!sel) base_a = widx;
        if (sel) blk_start_b = 1'b1;
        else     blk_start_a = 1'b1;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk); #1;
            blk_start_a = 1'b0;
            blk_start_b = 1'b0;
            if (rnd) begin
                msg_valid = 1'($urandom_range(0, 1));
                w_ready   = 1'($urandom_range(0, 1));
            end
            if (poke && w_valid_a && round_a == 7'd5) blk_start_a = 1'b1;
            if (sel ? done_b : done_a) begin
                lat = n;
                if (poke) blk_start_a = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        blk_start_a = 1'b0;
        msg_valid   = 1'b1;
        w_ready     = 1'b1;
    endtask

    int          lat;
    int          s_ld, s_st, s_dn, s_dn_b, s_st_b, bad;
    logic [31:0] ref_w [64];

    initial begin
        // Reset: outputs low during and after reset
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs_a", outs_a(), 32'h0);
        check("reset_outs_b", outs_b(), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_outs_a", outs_a(), 32'h0);

        // T1: SHA-256 "abc", no stalls
        s_ld = loads_a; s_st = starts_a; s_dn = dones_a;
        run_block(1'b0, 1'b0, 1'b0, lat);
        check("t1_latency", 32'(lat), 32'd81);
        check("t1_loads", 32'(loads_a - s_ld), 32'd16);
        check("t1_starts", 32'(starts_a - s_st), 32'd64);
        check("t1_dones", 32'(dones_a - s_dn), 32'd1);
        check("t1_w0", w_log[0], 32'h61626380);
        check("t1_w16", w_log[16], 32'h61626380);
        check("t1_w17", w_log[17], 32'h000F0000);
        check("t1_w63", w_log[63], 32'h12B1EDEB);
        for (int i = 0; i < 64; i++) ref_w[i] = w_log[i];

        // T2: SHA-512 round count
        s_st_b = starts_b; s_dn_b = dones_b;
        run_block(1'b1, 1'b0, 1'b0, lat);
        check("t2_latency", 32'(lat), 32'd97);
        check("t2_starts", 32'(starts_b - s_st_b), 32'd80);
        check("t2_dones", 32'(dones_b - s_dn_b), 32'd1);
        bad = 0;
        for (int i = 0; i < 80; i++) if (rlog_b[i] !== 7'(i)) bad++;
        check("t2_round_tags", 32'(bad), 32'd0);
        check("t2_round_range", 32'(range_err), 32'd0);

        // T3: random stalls on both handshakes
        s_ld = loads_a; s_st = starts_a; s_dn = dones_a;
        run_block(1'b0, 1'b1, 1'b0, lat);
        check("t3_done_seen", 32'(lat > 0), 32'd1);
        check("t3_loads", 32'(loads_a - s_ld), 32'd16);
        check("t3_starts", 32'(starts_a - s_st), 32'd64);
        bad = 0;
        for (int i = 0; i < 64; i++) if (w_log[i] !== ref_w[i]) bad++;
        check("t3_w_sequence", 32'(bad), 32'd0);
        check("t3_hold", 32'(hold_err), 32'd0);

        // T4: abort at round 20, then a clean block
        s_dn = dones_a;
        base_a = widx;
        blk_start_a = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            blk_start_a = 1'b0;
            if (w_valid_a && round_a == 7'd20) break;
        end
        check("t4_at_round20", 32'(round_a), 32'd20);
        abort = 1'b1;
        #1;
        check("t4_start_gated", 32'(sched_start_a), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("t4_busy_after", 32'(busy_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_done", 32'(dones_a - s_dn), 32'd0);
        s_dn = dones_a;
        run_block(1'b0, 1'b0, 1'b0, lat);
        check("t4_latency", 32'(lat), 32'd81);
        check("t4_dones", 32'(dones_a - s_dn), 32'd1);
        check("t4_w63", w_log[63], 32'h12B1EDEB);

        // T5: reset during LOAD after 7 words
        s_ld = loads_a;
        base_a = widx;
        blk_start_a = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            blk_start_a = 1'b0;
            if (loads_a - s_ld == 7) break;
        end
        check("t5_seven_loaded", 32'(loads_a - s_ld), 32'd7);
        rst = 1'b0;
        #1;
        check("t5_outs_in_reset", outs_a(), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_outs_after", outs_a(), 32'h0);
        s_ld = loads_a;
        run_block(1'b0, 1'b0, 1'b0, lat);
        check("t5_loads", 32'(loads_a - s_ld), 32'd16);
        check("t5_latency", 32'(lat), 32'd81);
        check("t5_w63", w_log[63], 32'h12B1EDEB);

        // T6: blk_start during RUN and DONE is ignored
        s_dn = dones_a; s_st = starts_a;
        run_block(1'b0, 1'b0, 1'b1, lat);
        check("t6_latency", 32'(lat), 32'd81);
        repeat (4) @(posedge clk);
        #1;
        check("t6_busy_idle", 32'(busy_a), 32'd0);
        check("t6_dones", 32'(dones_a - s_dn), 32'd1);
        check("t6_starts", 32'(starts_a - s_st), 32'd64);

        check("exclusive_strobes", 32'(excl_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
